// File: rtl/mmu_pkg.sv
// Shared types and width helpers for the MMU walker.
// State encoding, PTE layout and VPN/PPN width derivation.
package mmu_pkg;

  localparam int ADDR_W        = 16;
  localparam int PTE_VALID_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    WALK_REQ,
    WALK_RSP,
    ACCESS,
    COMPLETE
  } state_t;

  function automatic int vpn_w(input int off);
    return ADDR_W - off;
  endfunction

  function automatic int ppn_w(input int off);
    return ADDR_W - off;
  endfunction

endpackage

// File: rtl/mmu_walker_if.sv
// Processor-side request/response bundle of the MMU walker.
// master = requester, slave = walker.
interface mmu_walker_if;

  logic        req;
  logic        we;
  logic [15:0] vaddr;
  logic [15:0] wdata;
  logic        flush;
  logic        ready;
  logic        done;
  logic        fault;
  logic [15:0] rdata;

  modport master (
    output req, we, vaddr, wdata, flush,
    input  ready, done, fault, rdata
  );

  modport slave (
    input  req, we, vaddr, wdata, flush,
    output ready, done, fault, rdata
  );

endinterface

// File: rtl/mmu_walker_tlb_cam.sv
// Fully associative translation cache with round-robin refill.
// Lookup is combinational; flush masks the lookup in the same cycle.
module tlb_cam
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VW      = 8,
  parameter int PW      = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          flush,
  input  logic [VW-1:0] lookup_vpn,
  output logic          hit,
  output logic [PW-1:0] hit_ppn,
  input  logic          install,
  input  logic [VW-1:0] install_vpn,
  input  logic [PW-1:0] install_ppn
);

  localparam int IW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] match;
  logic [VW-1:0]      vpn_q [ENTRIES];
  logic [PW-1:0]      ppn_q [ENTRIES];
  logic [IW-1:0]      victim;

  always_comb begin
    match   = '0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid[i] && (vpn_q[i] == lookup_vpn);
      if (match[i]) hit_ppn = hit_ppn | ppn_q[i];
    end
    hit = (|match) && !flush;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid  <= '0;
      victim <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (install) begin
      valid[victim] <= 1'b1;
      victim        <= victim + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && !flush && install) begin
      vpn_q[victim] <= install_vpn;
      ppn_q[victim] <= install_ppn;
    end
  end

endmodule

// File: rtl/mmu_walker.sv
// Translating memory-access stage: cache lookup, page walk on
// miss, then one RAM access per request with a done/fault pulse.
module mmu_walker
  import mmu_pkg::*;
#(
  parameter int          ENTRIES     = 4,
  parameter int          OFFSET_BITS = 8,
  parameter logic [15:0] PT_BASE     = 16'hFE00
) (
  input  logic         clock,
  input  logic         resetn,
  mmu_walker_if.slave  bus,
  output logic [15:0]  miss_count,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_wdata,
  output logic         mem_we,
  input  logic [15:0]  mem_rdata
);

  localparam int VW = vpn_w(OFFSET_BITS);
  localparam int PW = ppn_w(OFFSET_BITS);

  state_t        state, state_n;
  logic          lat_we;
  logic [15:0]   lat_vaddr;
  logic [15:0]   lat_wdata;
  logic [PW-1:0] lat_ppn;
  logic [15:0]   rdata_q;

  logic          idle, accept, flush_en;
  logic          hit, pte_ok, install;
  logic [PW-1:0] hit_ppn;
  logic [VW-1:0] req_vpn, lat_vpn;

  assign idle     = (state == IDLE);
  assign accept   = idle && bus.req;
  assign flush_en = idle && bus.flush;
  assign req_vpn  = bus.vaddr[15:OFFSET_BITS];
  assign lat_vpn  = lat_vaddr[15:OFFSET_BITS];
  assign pte_ok   = mem_rdata[PTE_VALID_BIT];
  assign install  = (state == WALK_RSP) && pte_ok;

  tlb_cam #(
    .ENTRIES (ENTRIES),
    .VW      (VW),
    .PW      (PW)
  ) u_cam (
    .clock       (clock),
    .resetn      (resetn),
    .flush       (flush_en),
    .lookup_vpn  (req_vpn),
    .hit         (hit),
    .hit_ppn     (hit_ppn),
    .install     (install),
    .install_vpn (lat_vpn),
    .install_ppn (mem_rdata[PW-1:0])
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lat_we     <= 1'b0;
      lat_vaddr  <= '0;
      lat_wdata  <= '0;
      lat_ppn    <= '0;
      rdata_q    <= '0;
      miss_count <= '0;
    end else begin
      if (accept) begin
        lat_we    <= bus.we;
        lat_vaddr <= bus.vaddr;
        lat_wdata <= bus.wdata;
        lat_ppn   <= hit_ppn;
        if (!hit && miss_count != 16'hFFFF)
          miss_count <= miss_count + 16'd1;
      end
      if (install) lat_ppn <= mem_rdata[PW-1:0];
      if (state == COMPLETE && !lat_we) rdata_q <= mem_rdata;
    end
  end

  // Loads present RAM data during the done cycle itself.
  always_comb begin
    state_n   = state;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    bus.fault = 1'b0;
    bus.rdata = rdata_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.req) state_n = hit ? ACCESS : WALK_REQ;
      end
      WALK_REQ: begin
        mem_addr = PT_BASE + 16'(lat_vpn);
        state_n  = WALK_RSP;
      end
      WALK_RSP: begin
        if (pte_ok) begin
          state_n = ACCESS;
        end else begin
          bus.fault = resetn;
          state_n   = IDLE;
        end
      end
      ACCESS: begin
        mem_addr  = {lat_ppn, lat_vaddr[OFFSET_BITS-1:0]};
        mem_we    = lat_we;
        mem_wdata = lat_wdata;
        state_n   = COMPLETE;
      end
      COMPLETE: begin
        bus.done = resetn;
        if (!lat_we) bus.rdata = mem_rdata;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmu_walker.sv
// Bench for mmu_walker: transaction-level model with a FIFO cache
// and shadow memory, cycle traces checked on every falling edge.
module tb_mmu_walker;

  logic        clock;
  logic        resetn;
  logic [15:0] miss_count;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  mmu_walker_if bus();

  mmu_walker #(
    .ENTRIES     (4),
    .OFFSET_BITS (8),
    .PT_BASE     (16'hFE00)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .bus        (bus),
    .miss_count (miss_count),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        ready;
    logic        done;
    logic        fault;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] mc;
  } exp_t;

  logic [15:0] ram [65536];
  logic [15:0] mm  [65536];
  logic [7:0]  tq_vpn [$];
  logic [7:0]  tq_ppn [$];
  exp_t        exp_q  [$];
  logic [15:0] m_rdata;
  logic [15:0] m_mc;
  int          total;
  int          bad;
  int          we_pulses;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      we_pulses++;
    end
  end

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ready",      16'(bus.ready), 16'(e.ready));
      chk("done",       16'(bus.done),  16'(e.done));
      chk("fault",      16'(bus.fault), 16'(e.fault));
      chk("mem_we",     16'(mem_we),    16'(e.we));
      chk("mem_addr",   mem_addr,       e.addr);
      chk("mem_wdata",  mem_wdata,      e.wdata);
      chk("rdata",      bus.rdata,      e.rdata);
      chk("miss_count", miss_count,     e.mc);
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] d);
    ram[a] = d;
    mm[a]  = d;
  endtask

  task automatic model_reset();
    tq_vpn.delete();
    tq_ppn.delete();
    m_rdata = 16'h0;
    m_mc    = 16'h0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic idle_cyc(input logic fl);
    exp_t e;
    if (fl) begin
      tq_vpn.delete();
      tq_ppn.delete();
    end
    e = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, m_rdata, m_mc};
    exp_q.push_back(e);
    bus.flush = fl;
    cycle();
    bus.flush = 1'b0;
  endtask

  task automatic do_tx(input logic w, input logic [15:0] va,
                       input logic [15:0] wd, input logic fl,
                       input bit noise);
    exp_t        e;
    logic [7:0]  vpn, ppn;
    logic [15:0] pte, pa;
    bit          h, ok;
    int          n;
    vpn = va[15:8];
    ppn = 8'h0;
    if (fl) begin
      tq_vpn.delete();
      tq_ppn.delete();
    end
    h = 0;
    foreach (tq_vpn[i]) begin
      if (tq_vpn[i] == vpn) begin
        h   = 1;
        ppn = tq_ppn[i];
      end
    end
    e = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, m_rdata, m_mc};
    exp_q.push_back(e);
    n  = 1;
    ok = 1;
    if (!h) begin
      if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
      pte = mm[16'hFE00 + 16'(vpn)];
      e = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFE00 + 16'(vpn), 16'h0, m_rdata, m_mc};
      exp_q.push_back(e);
      e.addr  = 16'h0;
      e.fault = !pte[15];
      exp_q.push_back(e);
      n += 2;
      ok = pte[15];
      if (ok) begin
        if (tq_vpn.size() == 4) begin
          void'(tq_vpn.pop_front());
          void'(tq_ppn.pop_front());
        end
        ppn = pte[7:0];
        tq_vpn.push_back(vpn);
        tq_ppn.push_back(ppn);
      end
    end
    if (ok) begin
      pa = {ppn, va[7:0]};
      e = '{1'b0, 1'b0, 1'b0, w, pa, wd, m_rdata, m_mc};
      exp_q.push_back(e);
      if (w) mm[pa] = wd;
      else   m_rdata = mm[pa];
      e = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, m_rdata, m_mc};
      exp_q.push_back(e);
      n += 2;
    end
    bus.req   = 1'b1;
    bus.we    = w;
    bus.vaddr = va;
    bus.wdata = wd;
    bus.flush = fl;
    cycle();
    for (int k = 1; k < n; k++) begin
      bus.req   = noise ? 1'($urandom) : 1'b0;
      bus.flush = noise ? 1'($urandom) : 1'b0;
      bus.we    = 1'($urandom);
      bus.vaddr = 16'($urandom);
      bus.wdata = 16'($urandom);
      cycle();
    end
    bus.req   = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    total = 0;
    bad   = 0;
    we_pulses = 0;
    bus.req = 1'b0; bus.we = 1'b0; bus.flush = 1'b0;
    bus.vaddr = 16'h0; bus.wdata = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'(i * 7 + 3);
      mm[i]  = 16'(i * 7 + 3);
    end
    resetn = 1'b0;
    cycle();
    do_reset();
    chk("rst_ready", 16'(bus.ready), 16'h1);
    chk("rst_done",  16'(bus.done),  16'h0);
    chk("rst_fault", 16'(bus.fault), 16'h0);
    chk("rst_mc",    miss_count,     16'h0);
    chk("rst_rdata", bus.rdata,      16'h0);
    chk("rst_maddr", mem_addr,       16'h0);
    chk("rst_mwe",   16'(mem_we),    16'h0);

    set_mem(16'hFE12, 16'h8005);
    set_mem(16'h0534, 16'hBEEF);
    set_mem(16'h0520, 16'h1357);
    set_mem(16'hFE33, 16'h0007);
    do_tx(1'b0, 16'h1234, 16'h0, 1'b0, 1'b0);
    chk("tp1_rdata", bus.rdata,  16'hBEEF);
    chk("tp1_mc",    miss_count, 16'h1);
    do_tx(1'b0, 16'h1220, 16'h0, 1'b0, 1'b0);
    chk("tp2_rdata", bus.rdata,  16'h1357);
    chk("tp2_mc",    miss_count, 16'h1);
    p0 = we_pulses;
    do_tx(1'b1, 16'h1210, 16'hA5A5, 1'b0, 1'b0);
    chk("tp3_pulses", 16'(we_pulses - p0), 16'h1);
    chk("tp3_ram",    ram[16'h0510],       16'hA5A5);
    chk("tp3_rdata",  bus.rdata,           16'h1357);
    p0 = we_pulses;
    do_tx(1'b1, 16'h3300, 16'h7777, 1'b0, 1'b0);
    chk("tp4_pulses", 16'(we_pulses - p0), 16'h0);
    chk("tp4_ready",  16'(bus.ready),      16'h1);
    chk("tp4_mc",     miss_count,          16'h2);

    do_reset();
    for (int v = 1; v <= 5; v++)
      set_mem(16'hFE00 + 16'(v), 16'h8010 + 16'(v));
    for (int v = 1; v <= 5; v++)
      do_tx(1'b0, {8'(v), 8'h40}, 16'h0, 1'b0, 1'b0);
    chk("evict_mc5", miss_count, 16'h5);
    do_tx(1'b0, 16'h0140, 16'h0, 1'b0, 1'b0);
    chk("evict_mc6", miss_count, 16'h6);
    do_tx(1'b0, 16'h0540, 16'h0, 1'b0, 1'b0);
    chk("hit05_mc",  miss_count, 16'h6);
    do_tx(1'b0, 16'h0310, 16'h0, 1'b1, 1'b0);
    chk("flush_mc",  miss_count, 16'h7);

    bus.req = 1'b1; bus.we = 1'b1; bus.vaddr = 16'h0400;
    bus.wdata = 16'hDEAD;
    p0 = we_pulses;
    cycle();
    bus.req = 1'b0;
    cycle();
    resetn = 1'b0;
    @(negedge clock);
    chk("rstw_done",  16'(bus.done),  16'h0);
    chk("rstw_fault", 16'(bus.fault), 16'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    model_reset();
    @(negedge clock);
    chk("rstw_ready", 16'(bus.ready), 16'h1);
    chk("rstw_mc",    miss_count,     16'h0);
    chk("rstw_mwe",   16'(mem_we),    16'h0);
    @(posedge clock);
    #1;
    chk("rstw_pulse", 16'(we_pulses - p0), 16'h0);
    do_tx(1'b0, 16'h0310, 16'h0, 1'b0, 1'b0);
    chk("rstw_miss", miss_count, 16'h1);

    do_reset();
    for (int v = 0; v < 16; v++) begin
      logic [15:0] pte;
      pte      = 16'($urandom);
      pte[15]  = ($urandom_range(0, 3) != 0);
      pte[7:0] = 8'($urandom_range(0, 63));
      set_mem(16'hFE00 + 16'(v), pte);
    end
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 9) == 0)
        idle_cyc(1'($urandom));
      else
        do_tx(1'($urandom), {4'h0, 4'($urandom), 8'($urandom)},
              16'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
    end
    cycle();
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
